// File: rtl/wb_pkg.sv
// Shared constants and the LU result entry type for the writeback arbiter.
package wb_pkg;

  localparam int F_DEF          = 5;
  localparam int D_DEF          = 32;
  localparam int STARVE_MAX_DEF = 8;

  typedef struct packed {
    logic [F_DEF-1:0] wa;
    logic [D_DEF-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus between decode/ALU/LU sources and the writeback arbiter (slave side).
interface wb_arbiter_if #(
  parameter int F     = 5,
  parameter int D     = 32,
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          alu_we;
  logic [F-1:0]  alu_wa;
  logic [D-1:0]  alu_wd;
  logic          alu_stall;
  logic          lu_valid;
  logic          lu_ready;
  logic [F-1:0]  lu_wa;
  logic [D-1:0]  lu_wd;
  logic          issue_lu;
  logic [F-1:0]  issue_wa;
  logic [F-1:0]  ra1;
  logic [F-1:0]  ra2;
  logic          stall;
  logic          we3;
  logic [F-1:0]  wa3;
  logic [D-1:0]  wd3;
  logic [CW-1:0] fifo_count;

  modport master (
    output alu_we, alu_wa, alu_wd, lu_valid, lu_wa, lu_wd,
           issue_lu, issue_wa, ra1, ra2,
    input  alu_stall, lu_ready, stall, we3, wa3, wd3, fifo_count
  );

  modport slave (
    input  alu_we, alu_wa, alu_wd, lu_valid, lu_wa, lu_wd,
           issue_lu, issue_wa, ra1, ra2,
    output alu_stall, lu_ready, stall, we3, wa3, wd3, fifo_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of LU results; head is registered storage, no same-cycle bypass.
module wb_fifo
  import wb_pkg::*;
#(
  parameter type T     = wb_entry_t,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  output T              o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU-priority write port, LU result FIFO, pending scoreboard.
// Optional starvation guard for LU results is compiled in with WB_STARVE_GUARD_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int F          = F_DEF,
  parameter int D          = D_DEF,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       w_head;
  wb_entry_t       w_push_data;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_alu_sel;
  logic            w_alu_stall;
  logic            w_we;
  logic [F-1:0]    w_wa;
  logic [D-1:0]    w_wd;
  logic [CW-1:0]   w_count;
  logic [2**F-1:0] r_pending;

  // LU handshake: an entry transfers at posedge when lu_valid && lu_ready;
  // lu_ready depends only on FIFO fullness, never on lu_valid.
  assign bus.lu_ready = !w_full && !reset;
  assign w_push       = bus.lu_valid && bus.lu_ready;
  assign w_push_data  = '{wa: bus.lu_wa, wd: bus.lu_wd};

  wb_fifo #(.T(wb_entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] r_starve;

  assign w_alu_stall = !reset && !w_empty && (r_starve == SW'(STARVE_MAX));

  // Counts cycles the head is blocked by the ALU; any pop or empty FIFO clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (r_starve != SW'(STARVE_MAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_alu_stall = 1'b0;
`endif

  assign w_alu_sel = bus.alu_we && !w_alu_stall;
  assign w_pop     = !w_alu_sel && !w_empty && !reset;

  always_comb begin
    w_we = 1'b0;
    w_wa = bus.alu_wa;
    w_wd = bus.alu_wd;
    if (w_alu_sel) begin
      w_we = 1'b1;
    end else if (!w_empty) begin
      w_we = 1'b1;
      w_wa = w_head.wa;
      w_wd = w_head.wd;
    end
    // r0 is hardwired; the LU entry still pops but nothing is written.
    if (w_wa == '0 || reset) w_we = 1'b0;
  end

  assign bus.we3        = w_we;
  assign bus.wa3        = w_wa;
  assign bus.wd3        = w_wd;
  assign bus.alu_stall  = w_alu_stall;
  assign bus.fifo_count = w_count;

  // Set is written after clear so an issue to the register being retired wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      if (w_pop) r_pending[w_head.wa] <= 1'b0;
      if (bus.issue_lu && bus.issue_wa != '0) r_pending[bus.issue_wa] <= 1'b1;
    end
  end

  assign bus.stall = !reset && (
      (bus.ra1 != '0 && r_pending[bus.ra1]) ||
      (bus.ra2 != '0 && r_pending[bus.ra2]) ||
      (bus.issue_lu && bus.issue_wa != '0 && r_pending[bus.issue_wa]));

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file write port (we3/wa3/wd3).
- Merges two result sources onto the single write port:
  - single-cycle ALU results, which take priority;
  - long-latency unit (LU) results, which are buffered in a small FIFO.
- Keeps a pending scoreboard of registers awaiting LU results and raises `stall` for decode on read-after-write hazards against those registers.

Parameters:
- F, 5: register address width.
- D, 32: data width.
- DEPTH, 4: LU result FIFO depth; power of two, ≥2.
- STARVE_MAX, 8: consecutive blocked cycles before the starvation guard fires (optional feature only).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- alu_we  in  1  ALU result valid this cycle.
- alu_wa  in  F  ALU destination register.
- alu_wd  in  D  ALU result data.
- alu_stall  out  1  ALU writeback must hold its result this cycle.
- lu_valid  in  1  LU result offered.
- lu_ready  out  1  FIFO can accept an LU result.
- lu_wa  in  F  LU destination register.
- lu_wd  in  D  LU result data.
- issue_lu  in  1  decode issues an LU operation this cycle.
- issue_wa  in  F  destination of the issued LU operation.
- ra1, ra2  in  F  decode read addresses.
- stall  out  1  decode must not advance.
- we3  out  1  register file write enable.
- wa3  out  F  register file write address.
- wd3  out  D  register file write data.
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (asynchronous):
  - FIFO emptied, pointers 0, fifo_count=0.
  - pending[] all 0; starvation counter 0.
  - While reset is high, we3, lu_ready, stall and alu_stall are forced to 0.
  - Reset mid-operation discards buffered LU results and all pending bits.
- Write port (combinational):
  - Output is combinational from the current inputs and the FIFO head. The register file captures it on the negedge of the same cycle, so ALU writeback latency is 0 cycles.
  - Priority:
    - if alu_we and not alu_stall: we3=1, wa3=alu_wa, wd3=alu_wd;
    - else if FIFO not empty: we3=1, wa3/wd3 taken from the head entry, and the head pops at posedge;
    - else we3=0.
  - Any selected write with address 0 drives we3=0. An LU entry to r0 still pops.
- LU handshake:
  - lu_ready = FIFO not full.
  - Push at posedge when lu_valid & lu_ready.
  - A pushed entry becomes visible at the head no earlier than the next cycle, so there is no same-cycle bypass.
  - Simultaneous push and pop when full is not allowed (lu_ready=0). When the FIFO is not full, push and pop in the same cycle are both honoured and fifo_count is unchanged.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - issue_lu & issue_wa≠0 sets pending[issue_wa] at posedge.
  - A popped FIFO entry clears pending[wa] at posedge.
  - If a set and a clear hit the same register in one cycle, the set wins.
  - ALU writes never touch pending bits.
- Stall:
  - stall = (ra1≠0 & pending[ra1]) | (ra2≠0 & pending[ra2]) | (issue_lu & issue_wa≠0 & pending[issue_wa]).
  - The last term prevents write-after-write on an outstanding LU destination.
  - When stall is high, decode keeps issue_lu low until the hazard clears.
- alu_stall is 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- Defined:
  - A counter increments each cycle in which the FIFO is non-empty and the pop is blocked by an ALU write. It resets to 0 on any pop or when the FIFO is empty.
  - When the counter equals STARVE_MAX, alu_stall=1 for exactly that cycle. The FIFO head then writes, the counter clears, and the ALU source holds alu_we/alu_wa/alu_wd stable into the next cycle.
  - The counter saturates at STARVE_MAX.
- Undefined: no counter is present, alu_stall is tied to 0, and the ALU always wins.

Decomposition:
- Package wb_pkg holds:
  - default F and D constants;
  - typedef wb_entry_t as a packed struct {wa[F], wd[D]};
  - the STARVE_MAX default.
- One sub-module, wb_fifo: a parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count, asynchronous active-high reset.
- wb_arbiter instantiates wb_fifo and implements the arbitration, scoreboard and starvation logic.

Test Plan:
1. Reset release, alu_we=1, alu_wa=3, alu_wd=0xDEADBEEF → we3=1, wa3=3, wd3=0xDEADBEEF in the same cycle; stall=0.
2. Issue an LU operation to r5, then ra1=5 → stall=1. Push LU result (5, 0x1234) with alu_we=0 → one cycle later we3=1, wa3=5, wd3=0x1234. The following cycle stall=0 and pending[5]=0.
3. Push 4 LU results while alu_we=1 continuously → fifo_count=4, lu_ready=0. Drop alu_we → four writes in FIFO order over 4 cycles, then fifo_count=0 and lu_ready=1.
4. In the same cycle: issue_lu to r7 while the popped entry clears r7 → pending[7]=1 afterwards; ra2=7 → stall=1.
5. LU result to r0 → the entry pops, we3 stays 0, r0 reads 0. Assert reset with 3 entries queued → fifo_count=0 immediately and all pending bits cleared.
6. With WB_STARVE_GUARD_EN, one FIFO entry and alu_we held at 1 → alu_stall=1 after 8 blocked cycles and the FIFO entry is written that cycle. Without the macro → alu_stall never asserts.
